// File: rtl/bitreverser.sv
// Combinational bit mirror: o_dat[i] = i_dat[WIDTH-1-i].
module bitreverser #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_dat,
    output logic [WIDTH-1:0] o_dat
);

    for (genvar g = 0; g < WIDTH; g++) begin : g_rev
        assign o_dat[g] = i_dat[WIDTH-1-g];
    end

endmodule

// File: rtl/bit_deserializer.sv
// Serial-to-parallel receiver: packs valid/ready single-bit beats into WIDTH-bit
// words with selectable bit order and a one-entry output register.
module bit_deserializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     reset,
    input  logic                     clk,
    input  logic                     i_dat,
    input  logic                     i_sync,
    input  logic                     i_val,
    output logic                     o_rdy,
    output logic [WIDTH-1:0]         o_dat,
    output logic                     o_val,
    input  logic                     i_rdy,
    output logic [$clog2(WIDTH)-1:0] o_cnt
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int SW = WIDTH - 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0]    r_cnt;
    logic [SW-1:0]    r_sr;
    logic [WIDTH-1:0] r_dat;
    logic             r_val;

    logic             w_at_last;
    logic             w_acc;
    logic             w_done;
    logic [WIDTH-1:0] w_word;
    logic [WIDTH-1:0] w_out;

    assign w_at_last = (r_cnt == LAST);
    // Only the completing beat stalls; earlier bits can fill while a word waits.
    assign o_rdy     = !(w_at_last && r_val && !i_rdy);
    assign w_acc     = i_val && o_rdy;
    assign w_done    = w_acc && w_at_last && !i_sync;
    assign w_word    = {r_sr, i_dat};

    if (MSB_FIRST) begin : g_msb
        assign w_out = w_word;
    end else begin : g_lsb
        bitreverser #(.WIDTH(WIDTH)) u_rev (
            .i_dat (w_word),
            .o_dat (w_out)
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_sr  <= '0;
            r_dat <= '0;
            r_val <= 1'b0;
        end else begin
            if (w_acc) begin
                if (i_sync) begin
                    r_sr  <= SW'(i_dat);
                    r_cnt <= CW'(1);
                end else begin
                    r_sr  <= (r_sr << 1) | SW'(i_dat);
                    r_cnt <= w_at_last ? '0 : r_cnt + CW'(1);
                end
            end
            // A completing word overrides the drain so back-to-back words have no bubble.
            if (w_done) begin
                r_dat <= w_out;
                r_val <= 1'b1;
            end else if (i_rdy) begin
                r_val <= 1'b0;
            end
        end
    end

    assign o_dat = r_dat;
    assign o_val = r_val;
    assign o_cnt = r_cnt;

endmodule

// File: doc/bit_deserializer.md
Name: bit_deserializer

Overview:
- Serial-to-parallel receiver. It collects single-bit beats from a valid/ready stream into WIDTH-bit words and emits them on a parallel valid/ready stream.
- Bit order is selectable. MSB-first or LSB-first placement makes it the receiving end of a serialized parallel bus, including the bit-mirrored case.
- Sits between a serial source (link-layer bit pump or test pattern source) and word-oriented logic in the shared block set.

Parameters:
- WIDTH, 8, output word width in bits; legal range 2 and up.
- MSB_FIRST, 1, 1: first accepted bit lands in o_dat[WIDTH-1]; 0: first accepted bit lands in o_dat[0].

Ports:
- reset  input  1  asynchronous reset, active-high
- clk  input  1  single clock; all logic on rising edge
- i_dat  input  1  serial data bit
- i_sync  input  1  word-alignment marker; qualifies i_dat as bit 0 of a new word
- i_val  input  1  serial beat valid
- o_rdy  output  1  serial beat ready
- o_dat  output  WIDTH  assembled word
- o_val  output  1  word valid
- i_rdy  input  1  word ready from downstream
- o_cnt  output  $clog2(WIDTH)  bits held in the partial word (debug/status)

Behaviour:
- Reset (asynchronous, active-high): o_val=0, o_dat=0, o_cnt=0, shift register cleared. o_rdy=1 while reset is deasserted and state is idle.
- Serial beat accepted when i_val && o_rdy. Word transferred when o_val && i_rdy.
- Counter cnt runs 0..WIDTH-1 and increments on each accepted beat.
  - An accepted beat with cnt==WIDTH-1 completes the word; cnt wraps to 0.
- i_sync on an accepted beat:
  - The partial word is discarded.
  - The beat is stored as bit index 0 of a new word; cnt becomes 1.
  - i_sync is ignored when the beat is not accepted.
- Bit placement:
  - Bits are assembled internally MSB-first: shift left, new bit in LSB.
  - When MSB_FIRST=0 the completed word is mirrored via the existing bitreverser block before loading o_dat.
- Output register: single entry.
  - The completed word loads o_dat and sets o_val on the clock edge that accepts the last bit. o_val is seen the next cycle, so latency from last bit to o_val is 1 cycle.
  - o_val clears on transfer unless a new word completes in the same cycle.
- Back-pressure: o_rdy = !(cnt==WIDTH-1 && o_val && !i_rdy).
  - Only the completing beat stalls; partial bits keep flowing while the output word waits.
  - o_rdy is combinational from state and i_rdy; i_rdy-to-o_rdy is the only combinational path.
- Simultaneous load and drain: when the last bit is accepted in the same cycle the output is transferred, o_dat is replaced and o_val stays 1. This gives full throughput of one word per WIDTH beats with no bubble.
- i_sync on a completing beat (WIDTH==cnt+1 case): sync wins. No word is emitted; cnt becomes 1.
- o_dat holds its value while o_val=0 and while stalled. It is stable whenever o_val=1 && !i_rdy.
- Reset mid-word or mid-stall: partial bits and the pending word are dropped, and nothing is emitted.

Decomposition:
- No new package is needed. The counter width localparam CW = (WIDTH>1) ? $clog2(WIDTH) : 1 stays local.
- Sub-module: reuse bitreverser (WIDTH) on the assembled word, generated only when MSB_FIRST==0. No other sub-modules.

Test Plan:
- WIDTH=8, MSB_FIRST=1, i_rdy=1, bits 1,1,0,0,0,0,0,0 with i_sync on the first → o_dat=8'hC0, o_val=1 for one cycle, exactly 1 cycle after the 8th beat.
- Same stimulus with MSB_FIRST=0 → o_dat=8'h03. Then 1,0,1,1,0,0,0,0 → 8'h0D.
- i_rdy=0 while two words stream (bits of 8'hA5 then 8'h3C): first word held at 8'hA5 and beats 9..15 accepted. o_rdy=0 on beat 16 until i_rdy=1, then 8'h3C delivered next cycle with no data loss.
- i_sync asserted on the 5th beat of a word → first 4 bits discarded. Next word is formed from the sync beat plus 7 more, and o_val does not pulse for the aborted word.
- Continuous i_val=1, i_rdy=1 for 64 beats of an incrementing byte pattern 8'h00..8'h07 → 8 words in order, o_val pulsing every 8 cycles, o_rdy never low.
- reset asserted asynchronously mid-word (cnt=5) and during a stalled o_val → o_val=0, o_cnt=0 immediately. First word after release built only from post-reset beats.
